expr_check: RTL
===============

EXPR_CHECK -- requirements
Module: expr_check

Interface
REQ-001 Parameter MAX_DIGITS, default 4: maximum digits in one numeric literal, legal range 1-15.
REQ-002 Parameter MAX_DEPTH, default 3: maximum parenthesis nesting depth, legal range 1-15.
REQ-003 Parameter OP_MASK, default 4'b1111: operator enable; bit0 '+'(43), bit1 '-'(45), bit2 '*'(42), bit3 '/'(47).
REQ-004 Parameter DW, default 4: width of the depth output; the value SHALL be at least clog2(MAX_DEPTH+1).
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 clr  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  in carries a character this cycle.
REQ-008 in  input  8  ASCII character.
REQ-009 out  output  1  registered; the accepted prefix is a complete, balanced, valid expression.
REQ-010 err  output  1  registered, sticky; the current expression has been rejected.
REQ-011 done  output  1  one-cycle pulse; a terminator ';'(59) has been consumed.
REQ-012 ok  output  1  verdict for the terminated expression, valid only while done=1, 0 otherwise.
REQ-013 depth  output  DW  current open-parenthesis count.

Function
REQ-014 Grammar: expr := term (op term)*; term := number | '(' expr ')'; number := 1..MAX_DIGITS digits '0'-'9'; leading zeros are legal.
REQ-015 States: EXP_OPND (start, after an op or '('), IN_NUM, AFT_CLOSE (after ')'), ERROR.
REQ-016 Every transition SHALL occur only on a clock edge with in_valid=1; with in_valid=0, all state, out, err and depth SHALL hold and done SHALL be 0.
REQ-017 EXP_OPND: digit -> IN_NUM with digit count 1; '(' with depth<MAX_DEPTH -> depth+1, stay in EXP_OPND; '(' at depth=MAX_DEPTH -> ERROR; any other non-';' character -> ERROR.
REQ-018 IN_NUM: digit with count<MAX_DIGITS -> count+1; digit at count=MAX_DIGITS -> ERROR; enabled op -> EXP_OPND; ')' with depth>0 -> depth-1, AFT_CLOSE; ')' at depth=0 -> ERROR; any other non-';' character -> ERROR.
REQ-019 AFT_CLOSE: enabled op -> EXP_OPND; ')' SHALL follow the same rule as in IN_NUM; any other non-';' character, including a digit or '(', -> ERROR.
REQ-020 An op whose OP_MASK bit is 0 SHALL be treated as an illegal character.
REQ-021 ERROR: all non-';' characters are ignored; err=1; depth holds its last value.
REQ-022 On the cycle after any accepted character other than ';': out=1 if and only if the new state is IN_NUM or AFT_CLOSE and the new depth is 0.
REQ-023 err SHALL be 1 on every cycle where the state is ERROR.
REQ-024 ';' in any state: done=1 for the next cycle.
REQ-025 ';' in any state: ok=1 if and only if the prior state is IN_NUM or AFT_CLOSE and depth=0.
REQ-026 ';' in any state: the next state is EXP_OPND, and depth, digit count, out and err are all 0.
REQ-027 ';' on an empty expression (state EXP_OPND, depth 0) SHALL give done=1 and ok=0.
REQ-028 Back-to-back ';' characters SHALL each produce a done pulse, so done stays high for consecutive cycles.
REQ-029 Digit counting SHALL saturate and never wrap; depth SHALL never exceed MAX_DEPTH and never underflow.

Reset
REQ-030 When clr=0 at a rising edge, the block SHALL enter EXP_OPND with out=0, err=0, done=0, ok=0, depth=0 and digit count 0, regardless of in_valid.
REQ-031 Reset asserted mid-expression SHALL discard all partial state, and no done pulse SHALL be generated.
REQ-032 The block SHALL have no initial-value dependence; behaviour SHALL be defined only after the first reset.

Verification
REQ-033 Stream "12+3;" at defaults -> out is 1,1,0,1 after each character; done=1 with ok=1 after ';'; depth stays 0.
REQ-034 Stream "(1*(2-3));" -> depth reads 1,1,1,2,2,2,2,1,0; out=1 only after the final ')'; ok=1.
REQ-035 Stream "12345;" at MAX_DIGITS=4 -> err=1 after the 5th digit; ';' gives done=1, ok=0, and err clears on the following cycle.
REQ-036 Stream "((((1;" at MAX_DEPTH=3 -> err=1 after the 4th '('; depth holds 3; ok=0 on ';'.
REQ-037 Stream "1/2;" with OP_MASK=4'b0111 -> err=1 after '/'; ok=0; then "7;" -> ok=1.
REQ-038 Stream "(5" with in_valid gaps, then clr=0 for 1 cycle, then "5;" -> outputs freeze during the gaps; after reset depth=0 with no done pulse; the final ';' gives ok=1.

Source files
------------

// File: rtl/expr_check_if.sv
// Character stream in, verdict/status out, for the expression checker.
interface expr_check_if #(parameter int DW = 4);
  logic          in_valid;
  logic [7:0]    in;
  logic          out;
  logic          err;
  logic          done;
  logic          ok;
  logic [DW-1:0] depth;

  modport master (output in_valid, in, input out, err, done, ok, depth);
  modport slave  (input in_valid, in, output out, err, done, ok, depth);
endinterface

// File: rtl/expr_check.sv
// Streaming syntax checker for parenthesised integer expressions.
// state     | meaning
// EXP_OPND  | expecting an operand: start of expression, after an op or '('
// IN_NUM    | inside a numeric literal
// AFT_CLOSE | just consumed a ')'
// ERROR     | expression rejected; ignore input until ';'
module expr_check #(
  parameter int         MAX_DIGITS = 4,
  parameter int         MAX_DEPTH  = 3,
  parameter logic [3:0] OP_MASK    = 4'b1111,
  parameter int         DW         = 4
) (
  input logic        clk,
  input logic        clr,
  expr_check_if.slave bus
);

  typedef enum logic [1:0] {EXP_OPND, IN_NUM, AFT_CLOSE, ERROR} state_t;

  localparam logic [3:0]    MAXN = 4'(MAX_DIGITS);
  localparam logic [DW-1:0] MAXD = DW'(MAX_DEPTH);

  state_t        state_q, state_n;
  logic [DW-1:0] depth_q, depth_n;
  logic [3:0]    cnt_q, cnt_n;
  logic          done_q, done_n;
  logic          ok_q, ok_n;

  logic is_digit, is_op, is_open, is_close, is_term;

  always_comb begin
    is_digit = (bus.in >= 8'd48) && (bus.in <= 8'd57);
    is_op    = (bus.in == 8'd43 && OP_MASK[0]) || (bus.in == 8'd45 && OP_MASK[1]) ||
               (bus.in == 8'd42 && OP_MASK[2]) || (bus.in == 8'd47 && OP_MASK[3]);
    is_open  = (bus.in == 8'd40);
    is_close = (bus.in == 8'd41);
    is_term  = (bus.in == 8'd59);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= EXP_OPND;
      depth_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      depth_q <= depth_n;
      cnt_q   <= cnt_n;
      done_q  <= done_n;
      ok_q    <= ok_n;
    end
  end

  always_comb begin
    state_n = state_q;
    depth_n = depth_q;
    cnt_n   = cnt_q;
    done_n  = 1'b0;
    ok_n    = 1'b0;
    if (bus.in_valid) begin
      if (is_term) begin
        done_n  = 1'b1;
        ok_n    = (state_q == IN_NUM || state_q == AFT_CLOSE) && (depth_q == '0);
        state_n = EXP_OPND;
        depth_n = '0;
        cnt_n   = '0;
      end else begin
        case (state_q)
          EXP_OPND: begin
            if (is_digit) begin
              state_n = IN_NUM;
              cnt_n   = 4'd1;
            end else if (is_open && depth_q < MAXD) begin
              depth_n = depth_q + 1'b1;
            end else begin
              state_n = ERROR;
            end
          end
          IN_NUM: begin
            if (is_digit && cnt_q < MAXN) begin
              cnt_n = cnt_q + 4'd1;
            end else if (is_op) begin
              state_n = EXP_OPND;
              cnt_n   = '0;
            end else if (is_close && depth_q != '0) begin
              state_n = AFT_CLOSE;
              depth_n = depth_q - 1'b1;
              cnt_n   = '0;
            end else begin
              state_n = ERROR;
            end
          end
          AFT_CLOSE: begin
            if (is_op) begin
              state_n = EXP_OPND;
            end else if (is_close && depth_q != '0) begin
              depth_n = depth_q - 1'b1;
            end else begin
              state_n = ERROR;
            end
          end
          default: state_n = ERROR;
        endcase
      end
    end
  end

  // out/err are pure functions of registered state, so they hold with it
  always_comb begin
    bus.out   = (state_q == IN_NUM || state_q == AFT_CLOSE) && (depth_q == '0);
    bus.err   = (state_q == ERROR);
    bus.done  = done_q;
    bus.ok    = ok_q;
    bus.depth = depth_q;
  end

endmodule
